// File: rtl/video_pkg.sv
// video_pkg: shared mode encodings, default luma weights and pipeline latency
package video_pkg;
  typedef enum logic [1:0] {
    MODE_COLOR = 2'b00,
    MODE_GREEN = 2'b01,
    MODE_AMBER = 2'b10,
    MODE_MONO  = 2'b11
  } mode_t;
  localparam int KR_DEF = 54;
  localparam int KG_DEF = 183;
  localparam int KB_DEF = 19;
  localparam int TINT_LATENCY = 3;
endpackage

// File: rtl/video_luma.sv
// video_luma: two-stage fixed-point RGB to luma (weighted products, rounded sum, clamp)
module video_luma #(
  parameter int IN_W = 6,
  parameter int KR = 54,
  parameter int KG = 183,
  parameter int KB = 19
) (
  input  logic            clk_vga,
  input  logic            rst_n,
  input  logic [IN_W-1:0] r,
  input  logic [IN_W-1:0] g,
  input  logic [IN_W-1:0] b,
  output logic [IN_W-1:0] y
);
  localparam logic [IN_W+7:0] KR_W = (IN_W+8)'(KR);
  localparam logic [IN_W+7:0] KG_W = (IN_W+8)'(KG);
  localparam logic [IN_W+7:0] KB_W = (IN_W+8)'(KB);
  logic [IN_W+7:0] pr, pg, pb;
  logic [IN_W+9:0] sum;
  logic [IN_W+1:0] yr;
  assign sum = {2'b0, pr} + {2'b0, pg} + {2'b0, pb} + (IN_W+10)'(128);
  assign yr  = (IN_W+2)'(sum >> 8);
  // stage 1 multiplies, stage 2 rounds and saturates to the component range
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      pr <= '0;
      pg <= '0;
      pb <= '0;
      y  <= '0;
    end else begin
      pr <= KR_W * (IN_W+8)'(r);
      pg <= KG_W * (IN_W+8)'(g);
      pb <= KB_W * (IN_W+8)'(b);
      y  <= |yr[IN_W+1:IN_W] ? '1 : yr[IN_W-1:0];
    end
  end
endmodule

// File: rtl/video_tint_pipe.sv
// video_tint_pipe: 3-stage RGB tint/phosphor filter with frame-aligned mode switch; VIDEO_TINT_PIPE_DITHER_EN adds 2x2 Bayer dither
module video_tint_pipe
  import video_pkg::*;
#(
  parameter int   IN_W   = 6,
  parameter int   OUT_W  = 3,
  parameter int   KR     = KR_DEF,
  parameter int   KG     = KG_DEF,
  parameter int   KB     = KB_DEF,
  parameter logic HS_ACT = 1'b0,
  parameter logic VS_ACT = 1'b0
) (
  input  logic             clk_vga,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  input  logic [1:0]       mode_in,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out,
  output logic [1:0]       mode_active
);
  logic [IN_W-1:0] r1, g1, b1, r2, g2, b2, y2;
  logic [IN_W-1:0] sr, sg, sb, dr, dg, db;
  logic            hs1, vs1, de1, hs2, vs2, de2;
  logic [1:0]      mode1, mode2;
  logic            vs_edge;
  mode_t           m2;
  assign vs_edge = (vsync_in == VS_ACT) && (vs1 != VS_ACT);
  assign m2      = mode_t'(mode2);
  video_luma #(.IN_W(IN_W), .KR(KR), .KG(KG), .KB(KB)) u_luma (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .r       (r_in),
    .g       (g_in),
    .b       (b_in),
    .y       (y2)
  );
  // colour and timing ride alongside the luma stages; the mode only moves on vsync assertion
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      {r1, g1, b1, r2, g2, b2} <= '0;
      {hs1, hs2} <= {2{~HS_ACT}};
      {vs1, vs2} <= {2{~VS_ACT}};
      {de1, de2} <= '0;
      {mode1, mode2} <= '0;
      mode_active <= MODE_COLOR;
    end else begin
      {r1, g1, b1} <= {r_in, g_in, b_in};
      {r2, g2, b2} <= {r1, g1, b1};
      {hs1, vs1, de1} <= {hsync_in, vsync_in, de_in};
      {hs2, vs2, de2} <= {hs1, vs1, de1};
      mode1 <= mode_active;
      mode2 <= mode1;
      mode_active <= vs_edge ? mode_in : mode_active;
    end
  end
  // per-mode channel routing
  always_comb begin
    sr = m2 == MODE_COLOR ? r2 : m2 == MODE_GREEN ? '0 : y2;
    sg = m2 == MODE_COLOR ? g2 : m2 == MODE_AMBER ? y2 >> 1 : y2;
    sb = m2 == MODE_COLOR ? b2 : m2 == MODE_MONO ? y2 : '0;
  end
`ifdef VIDEO_TINT_PIPE_DITHER_EN
  logic          dx, dy;
  logic [IN_W:0] ofs;
  function automatic logic [IN_W-1:0] sat_add(input logic [IN_W-1:0] v, input logic [IN_W:0] o);
    logic [IN_W:0] s;
    s = {1'b0, v} + o;
    return s[IN_W] ? '1 : s[IN_W-1:0];
  endfunction
  // Bayer position: x flips per active pixel, y flips after each line and restarts at vsync
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      dx <= 1'b0;
      dy <= 1'b0;
    end else begin
      dx <= de2 ? ~dx : 1'b0;
      dy <= (vs2 == VS_ACT && vsync_out != VS_ACT) ? 1'b0 : (de_out && !de2) ? ~dy : dy;
    end
  end
  // add the scaled matrix entry below the kept bits, saturating at full scale
  always_comb begin
    ofs = (IN_W+1)'(dy ? (dx ? 1 : 3) : (dx ? 2 : 0)) << (IN_W - OUT_W - 2);
    dr  = sat_add(sr, ofs);
    dg  = sat_add(sg, ofs);
    db  = sat_add(sb, ofs);
  end
`else
  assign dr = sr;
  assign dg = sg;
  assign db = sb;
`endif
  // output stage: keep the top bits, force black during blanking
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      hsync_out <= ~HS_ACT;
      vsync_out <= ~VS_ACT;
      de_out    <= 1'b0;
    end else begin
      r_out     <= de2 ? OUT_W'(dr >> (IN_W - OUT_W)) : '0;
      g_out     <= de2 ? OUT_W'(dg >> (IN_W - OUT_W)) : '0;
      b_out     <= de2 ? OUT_W'(db >> (IN_W - OUT_W)) : '0;
      hsync_out <= hs2;
      vsync_out <= vs2;
      de_out    <= de2;
    end
  end
endmodule

// File: tb/tb_video_tint_pipe.sv
// tb_video_tint_pipe: scoreboard bench for video_tint_pipe (default build, no dither)
module tb_video_tint_pipe;
  logic       clk_vga = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hsync_in = 1'b1, vsync_in = 1'b1, de_in = 1'b0;
  logic [1:0] mode_in = '0;
  logic [2:0] r_out, g_out, b_out;
  logic       hsync_out, vsync_out, de_out;
  logic [1:0] mode_active;
  int         errors = 0;
  int         checks = 0;
  logic [11:0] sb[$];
  logic [1:0] model_mode = '0;
  logic       prev_vs = 1'b1;
  string      phase = "init";

  video_tint_pipe dut (
    .clk_vga(clk_vga), .rst_n(rst_n),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in), .mode_in(mode_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .mode_active(mode_active)
  );

  always #5 clk_vga = ~clk_vga;

  function automatic logic [11:0] exp_out(input logic [5:0] r, g, b, input logic hs, vs, de,
                                          input logic [1:0] m);
    int y;
    logic [5:0] yy, orr, og, ob;
    y = (54 * r + 183 * g + 19 * b + 128) / 256;
    if (y > 63) y = 63;
    yy = y[5:0];
    case (m)
      2'd0: begin orr = r;  og = g;       ob = b;  end
      2'd1: begin orr = 0;  og = yy;      ob = 0;  end
      2'd2: begin orr = yy; og = yy >> 1; ob = 0;  end
      default: begin orr = yy; og = yy;   ob = yy; end
    endcase
    if (!de) begin orr = 0; og = 0; ob = 0; end
    return {orr[5:3], og[5:3], ob[5:3], hs, vs, de};
  endfunction

  task automatic step(input logic [5:0] r, g, b, input logic hs, vs, de, input logic [1:0] m);
    logic [11:0] e, obs;
    @(negedge clk_vga);
    r_in = r; g_in = g; b_in = b;
    hsync_in = hs; vsync_in = vs; de_in = de; mode_in = m;
    sb.push_back(exp_out(r, g, b, hs, vs, de, model_mode));
    if (vs == 1'b0 && prev_vs != 1'b0) model_mode = m;
    prev_vs = vs;
    @(posedge clk_vga);
    #1;
    if (sb.size() == 3) begin
      e = sb.pop_front();
      obs = {r_out, g_out, b_out, hsync_out, vsync_out, de_out};
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s pixel: got %h want %h", phase, obs, e);
      end
    end
    checks++;
    assert (mode_active === model_mode) else begin
      errors++;
      $error("FAIL %s mode_active: got %0d want %0d", phase, mode_active, model_mode);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_vga);
    rst_n = 1'b0;
    r_in = 6'h3F; g_in = 6'h3F; b_in = 6'h3F;
    hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b1; mode_in = 2'd3;
    repeat (2) @(posedge clk_vga);
    #1;
    checks++;
    assert ({r_out, g_out, b_out, hsync_out, vsync_out, de_out} === 12'b000_000_000_110) else begin
      errors++;
      $error("FAIL %s reset outputs: got %h want %h", phase,
             {r_out, g_out, b_out, hsync_out, vsync_out, de_out}, 12'b000_000_000_110);
    end
    checks++;
    assert (mode_active === 2'd0) else begin
      errors++;
      $error("FAIL %s reset mode: got %0d want 0", phase, mode_active);
    end
    sb.delete();
    model_mode = '0;
    prev_vs = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic vsync_pulse(input logic [1:0] m_edge);
    step(0, 0, 0, 1, 0, 0, m_edge);
    step(0, 0, 0, 1, 0, 0, m_edge);
    step(0, 0, 0, 1, 1, 0, m_edge);
  endtask

  task automatic rand_line(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++)
      step(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1, 1, 1, m);
    step(0, 0, 0, 0, 1, 0, m);
    step(0, 0, 0, 1, 1, 0, m);
  endtask

  initial begin
    phase = "reset";
    do_reset();

    phase = "colour";
    vsync_pulse(2'd0);
    step(6'h3F, 6'h20, 6'h00, 1, 1, 1, 2'd0);
    step(6'h3F, 6'h20, 6'h00, 0, 1, 1, 2'd0);
    step(6'h12, 6'h2D, 6'h3F, 1, 1, 1, 2'd0);
    rand_line(4, 2'd0);

    phase = "latch";
    step(6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 2'd1);
    step(6'h3F, 6'h20, 6'h08, 1, 1, 1, 2'd1);
    rand_line(3, 2'd1);
    vsync_pulse(2'd1);
    phase = "green";
    step(6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 2'd1);
    rand_line(4, 2'd1);

    phase = "simul";
    step(0, 0, 0, 1, 1, 0, 2'd2);
    vsync_pulse(2'd3);
    phase = "white";
    step(6'h3F, 6'h00, 6'h00, 1, 1, 1, 2'd3);
    step(6'h00, 6'h3F, 6'h00, 1, 1, 1, 2'd3);
    rand_line(4, 2'd3);

    phase = "amber";
    vsync_pulse(2'd2);
    step(6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 2'd2);
    rand_line(4, 2'd2);

    phase = "blank";
    step(6'h3F, 6'h3F, 6'h3F, 1, 1, 0, 2'd2);
    step(6'h3F, 6'h3F, 6'h3F, 0, 1, 0, 2'd2);
    step(6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 2'd2);

    phase = "midreset";
    step(6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 2'd2);
    do_reset();
    phase = "resume";
    step(6'h3F, 6'h20, 6'h00, 1, 1, 1, 2'd2);
    rand_line(4, 2'd2);

    phase = "flush";
    repeat (3) step(0, 0, 0, 1, 1, 0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
